// File: rtl/decode_table.sv
// Programmable address-match/replace table on the bus datapath.
// Valid/ready lookup, config write port, saturating per-entry hit counters.
module decode_table #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int ENTRIES     = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 8,
  parameter int LEGACY_INIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_bus_out,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W-1:0]  stat_idx,
  output logic [CNT_W-1:0]  stat_count
);

  localparam bit PRELOAD = (LEGACY_INIT == 1) &&
                           (ADDR_W >= 8) &&
                           (DATA_W >= 8) &&
                           (ENTRIES >= 3);

  function automatic logic [7:0] pre_addr(input int i);
    unique case (i)
      0:       return 8'hF0;
      1:       return 8'h0F;
      default: return 8'hA0;
    endcase
  endfunction

  function automatic logic [7:0] pre_data(input int i);
    unique case (i)
      0:       return 8'h0F;
      1:       return 8'hF0;
      default: return 8'hFF;
    endcase
  endfunction

  logic              en_q   [ENTRIES];
  logic [ADDR_W-1:0] addr_q [ENTRIES];
  logic [DATA_W-1:0] data_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q  [ENTRIES];

  logic              accept;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [DATA_W-1:0] hit_data;
  logic [CNT_W-1:0]  stat_sel;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = data_bus_in;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (en_q[i] && addr_q[i] == addr_bus) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_data = data_q[i];
      end
    end
  end

  always_comb begin
    stat_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (stat_idx == IDX_W'(i)) stat_sel = cnt_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        en_q[i]   <= PRELOAD && (i < 3);
        addr_q[i] <= (PRELOAD && i < 3) ?
                     ADDR_W'(pre_addr(i)) : '0;
        data_q[i] <= (PRELOAD && i < 3) ?
                     DATA_W'(pre_data(i)) : '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          en_q[i]   <= cfg_en;
          addr_q[i] <= cfg_addr;
          data_q[i] <= cfg_data;
        end
      end
    end
  end

  // A config write clears the entry's counter, overriding a same-cycle hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          cnt_q[i] <= '0;
        end else if (accept && hit &&
                     hit_idx == IDX_W'(i) &&
                     cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      data_bus_out <= '0;
      out_hit      <= 1'b0;
      out_idx      <= '0;
      stat_count   <= '0;
    end else begin
      stat_count <= stat_sel;
      if (accept) begin
        out_valid    <= 1'b1;
        data_bus_out <= hit_data;
        out_hit      <= hit;
        out_idx      <= hit_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_table.sv
// Bench for decode_table: scoreboard of expected lookups plus
// per-scenario inline checks.
module tb_decode_table;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int EN = 4;
  localparam int IW = 3;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] addr_bus;
  logic [DW-1:0] data_bus_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_bus_out;
  logic          out_hit;
  logic [IW-1:0] out_idx;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [IW-1:0] stat_idx;
  logic [CW-1:0] stat_count;

  decode_table #(
    .DATA_W(DW), .ADDR_W(AW), .ENTRIES(EN),
    .IDX_W(IW), .CNT_W(CW), .LEGACY_INIT(1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .addr_bus(addr_bus), .data_bus_in(data_bus_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_bus_out(data_bus_out), .out_hit(out_hit),
    .out_idx(out_idx),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stat_idx(stat_idx), .stat_count(stat_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hit;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   popped = 0;

  logic          m_en  [EN];
  logic [AW-1:0] m_a   [EN];
  logic [DW-1:0] m_d   [EN];
  int            m_cnt [EN];

  task automatic model_reset();
    for (int i = 0; i < EN; i++) begin
      m_en[i] = 1'b0; m_a[i] = '0; m_d[i] = '0; m_cnt[i] = 0;
    end
    m_en[0] = 1; m_a[0] = 8'hF0; m_d[0] = 8'h0F;
    m_en[1] = 1; m_a[1] = 8'h0F; m_d[1] = 8'hF0;
    m_en[2] = 1; m_a[2] = 8'hA0; m_d[2] = 8'hFF;
    sb.delete();
  endtask

  // Scoreboard: inputs are stable at the falling edge, so what is seen
  // here is exactly what the next rising edge will act on.
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        vectors++;
        popped++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_extra: got data=%h hit=%b idx=%0d, required none",
                   data_bus_out, out_hit, out_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({data_bus_out, out_hit, out_idx} !== e) begin
            miscompares++;
            $display("FAIL sb_result: got data=%h hit=%b idx=%0d, required data=%h hit=%b idx=%0d",
                     data_bus_out, out_hit, out_idx, e.data, e.hit, e.idx);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = '{data: data_bus_in, hit: 1'b0, idx: '0};
        for (int i = 0; i < EN; i++) begin
          if (!e.hit && m_en[i] && m_a[i] == addr_bus) begin
            e = '{data: m_d[i], hit: 1'b1, idx: IW'(i)};
          end
        end
        sb.push_back(e);
        if (e.hit && m_cnt[e.idx] < 3) m_cnt[e.idx]++;
      end
      if (cfg_we && cfg_idx < EN) begin
        m_en[cfg_idx]  = cfg_en;
        m_a[cfg_idx]   = cfg_addr;
        m_d[cfg_idx]   = cfg_data;
        m_cnt[cfg_idx] = 0;
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    addr_bus = a; data_bus_in = d; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL send_timeout: addr=%h not accepted in 50 cycles", a);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [IW-1:0] i, input logic e,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_idx = i; cfg_en = e; cfg_addr = a; cfg_data = d; cfg_we = 1'b1;
    @(posedge clock); #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++;
    if ({out_valid, out_hit, out_idx, data_bus_out, stat_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got v=%b h=%b i=%0d d=%h s=%0d, required all 0",
               out_valid, out_hit, out_idx, data_bus_out, stat_count);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    model_reset();
    @(negedge clock); reset = 1'b1;
    idle(1);
  endtask

  task automatic test_legacy();
    logic [AW-1:0] la [4] = '{8'hF0, 8'h0F, 8'hA0, 8'h33};
    logic [DW-1:0] ld [4] = '{8'h0F, 8'hF0, 8'hFF, 8'h55};
    logic          lh [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(la[i], 8'h55);
      vectors++;
      if ({out_valid, data_bus_out, out_hit} !== {1'b1, ld[i], lh[i]}) begin
        miscompares++;
        $display("FAIL legacy_%0d: got v=%b d=%h h=%b, required v=1 d=%h h=%b",
                 i, out_valid, data_bus_out, out_hit, ld[i], lh[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_priority();
    cfg_write(1, 1, 8'h42, 8'h11);
    cfg_write(3, 1, 8'h42, 8'h22);
    send(8'h42, 8'h00);
    vectors++;
    if ({data_bus_out, out_idx} !== {8'h11, 3'd1}) begin
      miscompares++;
      $display("FAIL prio_low: got d=%h i=%0d, required d=11 i=1",
               data_bus_out, out_idx);
    end
    cfg_write(1, 0, 8'h42, 8'h11);
    send(8'h42, 8'h00);
    vectors++;
    if ({data_bus_out, out_idx} !== {8'h22, 3'd3}) begin
      miscompares++;
      $display("FAIL prio_dis: got d=%h i=%0d, required d=22 i=3",
               data_bus_out, out_idx);
    end
    cfg_write(5, 1, 8'h33, 8'h77);
    send(8'h33, 8'h5A);
    vectors++;
    if ({data_bus_out, out_hit, out_idx} !== {8'h5A, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL cfg_oob: got d=%h h=%b i=%0d, required d=5a h=0 i=0",
               data_bus_out, out_hit, out_idx);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int base = popped;
    logic [DW-1:0] held;
    fork
      begin
        send(8'hF0, 8'h01);
        send(8'h0F, 8'h02);
        send(8'h33, 8'h03);
        send(8'h42, 8'h04);
      end
      begin
        @(posedge clock); #2;
        out_ready = 1'b0;
        held = data_bus_out;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          vectors++;
          if ({in_ready, out_valid, data_bus_out} !== {1'b0, 1'b1, held}) begin
            miscompares++;
            $display("FAIL stall_%0d: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=%h",
                     k, in_ready, out_valid, data_bus_out, held);
          end
        end
        @(posedge clock); #2;
        out_ready = 1'b1;
      end
    join
    idle(3);
    vectors++;
    if (popped - base !== 4 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL stream_count: got %0d results (%0d left), required 4 (0 left)",
               popped - base, sb.size());
    end
  endtask

  task automatic test_collision();
    cfg_idx = 0; cfg_en = 1; cfg_addr = 8'hF0; cfg_data = 8'h99;
    cfg_we = 1'b1;
    send(8'hF0, 8'h00);
    cfg_we = 1'b0;
    vectors++;
    if (data_bus_out !== 8'h0F) begin
      miscompares++;
      $display("FAIL coll_old: got d=%h, required d=0f", data_bus_out);
    end
    stat_idx = 0;
    idle(2);
    vectors++;
    if (stat_count !== 2'd0) begin
      miscompares++;
      $display("FAIL coll_cnt: got %0d, required 0", stat_count);
    end
    send(8'hF0, 8'h00);
    vectors++;
    if (data_bus_out !== 8'h99) begin
      miscompares++;
      $display("FAIL coll_new: got d=%h, required d=99", data_bus_out);
    end
    idle(2);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) send(8'hA0, 8'h00);
    stat_idx = 2;
    idle(2);
    vectors++;
    if (stat_count !== 2'd3) begin
      miscompares++;
      $display("FAIL sat_cnt: got %0d, required 3", stat_count);
    end
    stat_idx = 1;
    idle(2);
    vectors++;
    if (int'(stat_count) !== m_cnt[1]) begin
      miscompares++;
      $display("FAIL cnt_e1: got %0d, required %0d", stat_count, m_cnt[1]);
    end
    stat_idx = 7;
    idle(2);
    vectors++;
    if (stat_count !== 2'd0) begin
      miscompares++;
      $display("FAIL stat_oob: got %0d, required 0", stat_count);
    end
  endtask

  task automatic test_reset_mid();
    stat_idx = 2;
    out_ready = 1'b0;
    send(8'h42, 8'h00);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, data_bus_out, stat_count} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got v=%b d=%h s=%0d, required all 0",
               out_valid, data_bus_out, stat_count);
    end
    model_reset();
    out_ready = 1'b1;
    @(negedge clock); reset = 1'b1;
    idle(2);
    vectors++;
    if (stat_count !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_cnt: got %0d, required 0", stat_count);
    end
    send(8'hF0, 8'h00);
    vectors++;
    if ({data_bus_out, out_hit} !== {8'h0F, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_pre0: got d=%h h=%b, required d=0f h=1",
               data_bus_out, out_hit);
    end
    send(8'h42, 8'h3C);
    vectors++;
    if ({data_bus_out, out_hit} !== {8'h3C, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_pre3: got d=%h h=%b, required d=3c h=0",
               data_bus_out, out_hit);
    end
    idle(2);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_left: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    in_valid = 0; addr_bus = '0; data_bus_in = '0; out_ready = 1;
    cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_addr = '0; cfg_data = '0;
    stat_idx = '0;
    test_reset();
    test_legacy();
    test_priority();
    test_back_to_back();
    test_collision();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
